// File: rtl/pwm_capture_pkg.sv
// Frame definition shared by the PWM generator and the capture block so both
// ends agree on channel count, window length and duty width.
package pwm_capture_pkg;

    localparam int unsigned PwmChannels = 8;
    localparam int unsigned PwmPeriod   = 101;
    localparam int unsigned PwmDw       = 7;

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM line: two-flop synchronizer feeding a saturating-free high-cycle
// accumulator that restarts on window wrap or sync.
module pwm_capture_chan #(
    parameter int unsigned DW = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pwm_i,
    input  logic          clear_i,
    input  logic          wrap_i,
    output logic [DW-1:0] sum_o
);

    logic [1:0]    sync_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            acc_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pwm_i};
            acc_q  <= acc_d;
        end
    end

    // Count including this cycle's sample, so the window's last cycle is captured.
    assign sum_o = acc_q + DW'(sync_q[1]);

    always_comb begin
        acc_d = sum_o;
        if (clear_i || wrap_i) begin
            acc_d = '0;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM duty capture: counts high cycles per fixed window and
// presents the result through a valid/ready handshake with sticky overrun.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CHANNELS = PwmChannels,
    parameter int unsigned PERIOD   = PwmPeriod,
    parameter int unsigned DW       = PwmDw
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [CHANNELS-1:0]    pwm_in,
    input  logic                   sync,
    output logic [CHANNELS*DW-1:0] duty,
    output logic                   valid,
    input  logic                   ready,
    output logic                   overrun,
    input  logic                   clear_ovr
);

    logic [DW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS*DW-1:0] duty_q, duty_d;
    logic [CHANNELS*DW-1:0] sums;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   wrap;

    // sync wins over the boundary: the window is discarded with no transfer.
    assign wrap = (cnt_q == DW'(PERIOD - 1)) && !sync;

    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_chan
        pwm_capture_chan #(
            .DW (DW)
        ) u_chan (
            .clk_i   (clock),
            .rst_ni  (reset_n),
            .pwm_i   (pwm_in[k]),
            .clear_i (sync),
            .wrap_i  (wrap),
            .sum_o   (sums[k*DW +: DW])
        );
    end

    always_comb begin
        cnt_d     = cnt_q + DW'(1);
        duty_d    = duty_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (sync || wrap) begin
            cnt_d = '0;
        end
        if (wrap) begin
            duty_d  = sums;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (wrap && valid_q && !ready) begin
            overrun_d = 1'b1;
        end else if (clear_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign duty    = duty_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule
